// File: rtl/ir_pulse_capture.sv
// IR receiver front-end: synchronise and glitch-filter the demodulated input, then
// time every mark/space in prescaled ticks and emit one record per completed pulse.
module ir_pulse_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int PRESCALE       = 12,
  parameter int WIDTH          = 16,
  parameter int IDLE_TICKS     = 10000,
  parameter int STRETCH_CYCLES = 131072,
  parameter bit RX_ACTIVE_LOW  = 1'b1
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             RXD_i,
  input  logic             EN_i,
  output logic [WIDTH-1:0] DUR_o,
  output logic             LEVEL_o,
  output logic             OVF_o,
  output logic             VALID_o,
  output logic             FRAME_END_o,
  output logic             BUSY_o,
  output logic             ACT_o
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int ACT_W  = $clog2(STRETCH_CYCLES + 1);
  localparam logic [WIDTH-1:0] DUR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH-1:0] v, input logic ovf_in);
    if (v == DUR_MAX) sat_inc = {1'b1, v};
    else              sat_inc = {ovf_in, v + WIDTH'(1)};
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   mark_s;
  logic [FCNT_W-1:0]      fcnt;
  logic                   filt_p1, filt_p2;
  logic                   fedge, mark_edge, space_edge;
  logic [PRE_W-1:0]       pre;
  logic                   tick;
  logic [WIDTH-1:0]       dur;
  logic                   ovf;
  logic [ACT_W-1:0]       act_cnt;
  state_t                 state, state_nxt;
  logic                   rec_stb, frame_stb;

  // p0: synchroniser, reset to the pin's inactive level
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) sync_p0 <= {SYNC_STAGES{RX_ACTIVE_LOW}};
    else         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], RXD_i};
  end

  assign mark_s = sync_p0[SYNC_STAGES-1] ^ RX_ACTIVE_LOW;

  // p1: glitch filter; same latency for both edge directions
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) begin
      filt_p1 <= 1'b0;
      fcnt    <= '0;
    end else if (mark_s == filt_p1) begin
      fcnt <= '0;
    end else if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
      filt_p1 <= mark_s;
      fcnt    <= '0;
    end else begin
      fcnt <= fcnt + FCNT_W'(1);
    end
  end

  // p2: edge detection drives the FSM, counters and activity stretcher
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) filt_p2 <= 1'b0;
    else         filt_p2 <= filt_p1;
  end

  assign fedge      = filt_p1 ^ filt_p2;
  assign mark_edge  = fedge & filt_p1;
  assign space_edge = fedge & ~filt_p1;
  assign tick       = (pre == PRE_W'(PRESCALE - 1));

  // The edge cycle is the first prescaler clock, so a P-clock pulse yields floor(P/PRESCALE).
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i || !EN_i) begin
      pre <= '0;
      dur <= '0;
      ovf <= 1'b0;
    end else if (fedge) begin
      pre <= PRE_W'(1);
      dur <= '0;
      ovf <= 1'b0;
    end else if (state != S_IDLE) begin
      if (tick) begin
        pre        <= '0;
        {ovf, dur} <= sat_inc(dur, ovf);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rec_stb   = 1'b0;
    frame_stb = 1'b0;
    if (!EN_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (mark_edge) state_nxt = S_MARK;
        S_MARK:  if (space_edge) begin
                   state_nxt = S_SPACE;
                   rec_stb   = 1'b1;
                 end
        S_SPACE: if (mark_edge) begin
                   state_nxt = S_MARK;
                   rec_stb   = 1'b1;
                 end else if (dur == WIDTH'(IDLE_TICKS)) begin
                   state_nxt = S_IDLE;
                   frame_stb = 1'b1;
                 end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // p3: registered record and status outputs
  always_ff @(posedge CLK_i) begin
    if (!RSTN_i) begin
      DUR_o       <= '0;
      LEVEL_o     <= 1'b0;
      OVF_o       <= 1'b0;
      VALID_o     <= 1'b0;
      FRAME_END_o <= 1'b0;
      BUSY_o      <= 1'b0;
    end else begin
      VALID_o     <= rec_stb;
      FRAME_END_o <= frame_stb;
      BUSY_o      <= (state_nxt != S_IDLE);
      if (rec_stb) begin
        DUR_o   <= dur;
        LEVEL_o <= (state == S_MARK);
        OVF_o   <= ovf;
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (!RSTN_i)            act_cnt <= '0;
    else if (mark_edge)     act_cnt <= ACT_W'(STRETCH_CYCLES);
    else if (act_cnt != '0) act_cnt <= act_cnt - ACT_W'(1);
  end

  assign ACT_o = (act_cnt != '0);

endmodule

// File: tb/tb_ir_pulse_capture.sv
// Bench for ir_pulse_capture: directed pulse scenarios plus random mark/space trains
// checked against a run-length reference model.
`timescale 1ns/1ps
module tb_ir_pulse_capture;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 3;
  localparam int PRESCALE       = 4;
  localparam int WIDTH          = 8;
  localparam int IDLE_TICKS     = 50;
  localparam int STRETCH_CYCLES = 20;
  localparam bit RX_ACTIVE_LOW  = 1'b1;
  localparam int LAT       = SYNC_STAGES + FILTER_LEN;
  localparam int IDLE_CLKS = IDLE_TICKS * PRESCALE;
  localparam int DMAX      = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             rxd = 1'b1;
  logic             en = 1'b1;
  logic [WIDTH-1:0] dur_o;
  logic             level_o, ovf_o, valid_o, frame_end_o, busy_o, act_o;

  ir_pulse_capture #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .PRESCALE(PRESCALE),
    .WIDTH(WIDTH), .IDLE_TICKS(IDLE_TICKS), .STRETCH_CYCLES(STRETCH_CYCLES),
    .RX_ACTIVE_LOW(RX_ACTIVE_LOW)
  ) dut (
    .CLK_i(clk), .RSTN_i(rstn), .RXD_i(rxd), .EN_i(en),
    .DUR_o(dur_o), .LEVEL_o(level_o), .OVF_o(ovf_o), .VALID_o(valid_o),
    .FRAME_END_o(frame_end_o), .BUSY_o(busy_o), .ACT_o(act_o)
  );

  always #5 clk = ~clk;

  typedef struct {bit lvl; int dur; bit ovf; int cyc;} rec_t;
  typedef struct {bit mark; int len; int ga; int gl;} run_t;

  int   cyc = 0;
  rec_t got_q[$];
  int   fe_n = 0, fe_cyc = 0, fe_busy = 0;
  int   busy_hi = 0, act_hi = 0, act_rise = 0, act_fall = 0;
  logic act_prev = 1'b0;
  int   n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    rec_t r;
    if (valid_o) begin
      r.lvl = level_o; r.dur = int'(dur_o); r.ovf = ovf_o; r.cyc = cyc;
      got_q.push_back(r);
    end
    if (frame_end_o) begin
      fe_n    = fe_n + 1;
      fe_cyc  = cyc;
      fe_busy = int'(busy_o);
    end
    if (busy_o) busy_hi = busy_hi + 1;
    if (act_o) act_hi = act_hi + 1;
    if (act_o && !act_prev) act_rise = cyc;
    if (!act_o && act_prev) act_fall = cyc;
    act_prev = act_o;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit mark, input int n);
    rxd = mark ? ~RX_ACTIVE_LOW : RX_ACTIVE_LOW;
    tick(n);
  endtask

  function automatic run_t mk(input bit m, input int l);
    run_t r;
    r.mark = m; r.len = l; r.ga = 0; r.gl = 0;
    return r;
  endfunction

  // Plays runs clock by clock; a glitch flips the level for gl clocks from offset ga.
  task automatic play(input run_t runs[$], output int last_start);
    last_start = 0;
    foreach (runs[i]) begin
      last_start = cyc;
      for (int k = 0; k < runs[i].len; k++) begin
        if (runs[i].gl > 0 && k >= runs[i].ga && k < runs[i].ga + runs[i].gl)
          rxd = runs[i].mark ? RX_ACTIVE_LOW : ~RX_ACTIVE_LOW;
        else
          rxd = runs[i].mark ? ~RX_ACTIVE_LOW : RX_ACTIVE_LOW;
        tick(1);
      end
    end
  endtask

  // Filtered waveform equals the run list; a space longer than the idle limit ends the frame.
  task automatic model(input run_t runs[$], output rec_t exp_q[$], output int n_fe);
    bit   cap;
    int   t;
    rec_t r;
    cap = 1'b0;
    n_fe = 0;
    exp_q.delete();
    foreach (runs[i]) begin
      t = runs[i].len / PRESCALE;
      r.cyc = 0;
      if (runs[i].mark) begin
        cap = 1'b1;
        if (i < runs.size() - 1) begin
          r.lvl = 1'b1; r.dur = (t > DMAX) ? DMAX : t; r.ovf = (t > DMAX);
          exp_q.push_back(r);
        end
      end else if (i > 0 && cap) begin
        if (runs[i].len > IDLE_CLKS) begin
          n_fe++;
          cap = 1'b0;
        end else if (i < runs.size() - 1) begin
          r.lvl = 1'b0; r.dur = t; r.ovf = 1'b0;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic check_recs(input string tag, input int base, input rec_t exp_q[$]);
    int n;
    n = got_q.size() - base;
    check({tag, "_nrec"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check($sformatf("%s_lvl%0d", tag, i), int'(got_q[base+i].lvl), int'(exp_q[i].lvl));
      check($sformatf("%s_dur%0d", tag, i), got_q[base+i].dur, exp_q[i].dur);
      check($sformatf("%s_ovf%0d", tag, i), int'(got_q[base+i].ovf), int'(exp_q[i].ovf));
    end
  endtask

  function automatic rec_t mr(input bit l, input int d, input bit o);
    rec_t r;
    r.lvl = l; r.dur = d; r.ovf = o; r.cyc = 0;
    return r;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   base, fe0, busy0, act0, t_fall, t_rise, t2, last;
    run_t runs[$];
    rec_t exp_q[$];
    int   n_fe;
    logic [WIDTH+5:0] outs;

    // Reset held while the input toggles
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd = ~rxd;
      tick(1);
    end
    @(negedge clk);
    outs = {dur_o, level_o, ovf_o, valid_o, frame_end_o, busy_o, act_o};
    check("reset_outs", int'(outs), 0);
    rxd = 1'b1;
    rstn = 1'b1;
    tick(10);
    outs = {dur_o, level_o, ovf_o, valid_o, frame_end_o, busy_o, act_o};
    check("post_reset_outs", int'(outs), 0);

    // Glitch shorter than the filter
    base = got_q.size(); busy0 = busy_hi; act0 = act_hi;
    drive(1'b1, 2);
    drive(1'b0, 30);
    check("glitch_nrec", got_q.size() - base, 0);
    check("glitch_busy", busy_hi - busy0, 0);
    check("glitch_act", act_hi - act0, 0);

    // Single 40-clock mark: latency, duration, activity stretch, frame end
    base = got_q.size(); fe0 = fe_n;
    t_fall = cyc;
    drive(1'b1, 40);
    t_rise = cyc;
    drive(1'b0, 300);
    exp_q = '{mr(1'b1, 10, 1'b0)};
    check_recs("single", base, exp_q);
    if (got_q.size() > base) check("single_lat", got_q[base].cyc, t_rise + LAT + 1);
    check("act_rise", act_rise, t_fall + LAT + 1);
    check("act_len", act_fall - act_rise, STRETCH_CYCLES);
    check("single_fe", fe_n - fe0, 1);
    check("single_fe_cyc", fe_cyc, t_rise + LAT + IDLE_CLKS + 1);
    check("single_fe_busy", fe_busy, 0);

    // Mark/space/mark sequence
    base = got_q.size(); fe0 = fe_n;
    runs = '{mk(1'b0, 10), mk(1'b1, 40), mk(1'b0, 20), mk(1'b1, 8), mk(1'b0, 300)};
    play(runs, last);
    tick(2);
    exp_q = '{mr(1'b1, 10, 1'b0), mr(1'b0, 5, 1'b0), mr(1'b1, 2, 1'b0)};
    check_recs("seq", base, exp_q);
    check("seq_fe", fe_n - fe0, 1);
    check("seq_fe_cyc", fe_cyc, last + LAT + IDLE_CLKS + 1);
    check("seq_fe_busy", fe_busy, 0);

    // Saturating mark
    base = got_q.size();
    runs = '{mk(1'b1, 1200), mk(1'b0, 300)};
    play(runs, last);
    exp_q = '{mr(1'b1, DMAX, 1'b1)};
    check_recs("sat", base, exp_q);

    // Space exactly at the idle limit (edge wins) and one clock beyond
    base = got_q.size(); fe0 = fe_n;
    runs = '{mk(1'b1, 20), mk(1'b0, IDLE_CLKS), mk(1'b1, 20), mk(1'b0, IDLE_CLKS + 1),
             mk(1'b1, 20), mk(1'b0, 300)};
    play(runs, last);
    exp_q = '{mr(1'b1, 5, 1'b0), mr(1'b0, IDLE_TICKS, 1'b0), mr(1'b1, 5, 1'b0), mr(1'b1, 5, 1'b0)};
    check_recs("idle_edge", base, exp_q);
    check("idle_edge_fe", fe_n - fe0, 2);

    // Retriggered activity stretcher
    t_fall = cyc;
    drive(1'b1, 8);
    drive(1'b0, 7);
    t2 = cyc;
    drive(1'b1, 8);
    drive(1'b0, 300);
    check("retrig_rise", act_rise, t_fall + LAT + 1);
    check("retrig_fall", act_fall, t2 + LAT + 1 + STRETCH_CYCLES);

    // Enable dropped mid-mark and raised while the mark continues
    base = got_q.size(); fe0 = fe_n;
    drive(1'b1, 20);
    en = 1'b0;
    drive(1'b1, 5);
    @(negedge clk);
    check("en_busy", int'(busy_o), 0);
    en = 1'b1;
    drive(1'b1, 20);
    drive(1'b0, 30);
    drive(1'b1, 12);
    drive(1'b0, 300);
    exp_q = '{mr(1'b1, 3, 1'b0)};
    check_recs("enable", base, exp_q);
    check("enable_fe", fe_n - fe0, 1);

    // Reset pulsed mid-mark
    base = got_q.size(); fe0 = fe_n;
    drive(1'b1, 20);
    rstn = 1'b0;
    tick(1);
    rxd = RX_ACTIVE_LOW;
    tick(2);
    rstn = 1'b1;
    drive(1'b0, 300);
    check("rst_mid_nrec", got_q.size() - base, 0);
    check("rst_mid_fe", fe_n - fe0, 0);
    check("rst_mid_busy", int'(busy_o), 0);

    // Random mark/space trains with glitches, boundary spaces and saturating marks
    for (int rnd = 0; rnd < 2; rnd++) begin
      base = got_q.size(); fe0 = fe_n;
      runs.delete();
      runs.push_back(mk(1'b0, 5));
      for (int i = 1; i < 60; i++) begin
        run_t r;
        int sel;
        sel = int'($urandom_range(0, 9));
        r = mk(i % 2 == 1, 0);
        if (r.mark) r.len = (sel == 0) ? int'($urandom_range(1000, 1200)) : int'($urandom_range(3, 100));
        else if (sel == 0) r.len = int'($urandom_range(IDLE_CLKS - 5, IDLE_CLKS + 5));
        else if (sel == 1) r.len = int'($urandom_range(IDLE_CLKS + 10, IDLE_CLKS + 120));
        else r.len = int'($urandom_range(3, 150));
        if (r.len >= 12 && $urandom_range(0, 3) == 0) begin
          r.gl = int'($urandom_range(1, 2));
          r.ga = int'($urandom_range(3, r.len - 1 - r.gl));
        end
        runs.push_back(r);
      end
      runs.push_back(mk(1'b0, 300));
      model(runs, exp_q, n_fe);
      play(runs, last);
      tick(2);
      check_recs($sformatf("rand%0d", rnd), base, exp_q);
      check($sformatf("rand%0d_fe", rnd), fe_n - fe0, n_fe);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
